// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mac_pkg
// Purpose  : Mode constants and saturation-limit helpers for the pipelined MAC.
// Revision : 1.0
// ============================================================================
package mac_pkg;

  localparam bit MAC_UNSIGNED = 1'b0;
  localparam bit MAC_SIGNED   = 1'b1;
  localparam bit MAC_WRAP     = 1'b0;
  localparam bit MAC_SAT      = 1'b1;

  localparam int c_ACC_WIDTH_LIMIT = 64;

  // Largest representable accumulator value, returned in the low `width` bits.
  function automatic logic [63:0] sat_max(input int width, input bit signed_mode);
    logic [63:0] lim;
    if (signed_mode == MAC_SIGNED) begin
      lim = (64'd1 << (width - 1)) - 64'd1;
    end else if (width >= 64) begin
      lim = '1;
    end else begin
      lim = (64'd1 << width) - 64'd1;
    end
    return lim;
  endfunction

  function automatic logic [63:0] sat_min(input int width, input bit signed_mode);
    logic [63:0] lim;
    if (signed_mode == MAC_SIGNED) begin
      lim = ~((64'd1 << (width - 1)) - 64'd1);
    end else begin
      lim = '0;
    end
    return lim;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_product_stage.sv
`default_nettype none
// ============================================================================
// Module   : mac_product_stage
// Purpose  : Operand qualification, exact multiply and extension to ACC_WIDTH+1.
// Revision : 1.0
// ============================================================================
module mac_product_stage
  import mac_pkg::*;
#(
  parameter int IN_WIDTH    = 8,
  parameter int ACC_WIDTH   = 24,
  parameter bit SIGNED_MODE = MAC_UNSIGNED
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_in_valid,
  input  logic                 i_clear_acc,
  input  logic [IN_WIDTH-1:0]  i_a,
  input  logic [IN_WIDTH-1:0]  i_b,
  output logic [ACC_WIDTH:0]   o_product,
  output logic                 o_p_valid,
  output logic                 o_p_clear
);

  localparam int c_PROD_W = 2 * IN_WIDTH;
  localparam int c_EXT_W  = ACC_WIDTH + 1 - c_PROD_W;

  logic [c_PROD_W-1:0] w_prod;
  logic                w_sign;
  logic [ACC_WIDTH:0]  w_product_d;
  logic [ACC_WIDTH:0]  r_product_q;
  logic                r_p_valid_q;
  logic                r_p_clear_q;

  always_comb begin
    // Low 2N bits of a product of extended operands are exact in either mode.
    if (SIGNED_MODE == MAC_SIGNED) begin
      w_prod = c_PROD_W'($signed(i_a)) * c_PROD_W'($signed(i_b));
      w_sign = w_prod[c_PROD_W-1];
    end else begin
      w_prod = c_PROD_W'(i_a) * c_PROD_W'(i_b);
      w_sign = 1'b0;
    end
    w_product_d = r_product_q;
    if (i_in_valid || i_clear_acc) begin
      w_product_d = {{c_EXT_W{w_sign}}, w_prod};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_product_q <= '0;
      r_p_valid_q <= 1'b0;
      r_p_clear_q <= 1'b0;
    end else begin
      r_product_q <= w_product_d;
      r_p_valid_q <= i_in_valid;
      r_p_clear_q <= i_clear_acc;
    end
  end

  assign o_product = r_product_q;
  assign o_p_valid = r_p_valid_q;
  assign o_p_clear = r_p_clear_q;

endmodule
`default_nettype wire

// File: rtl/mac_accumulator_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : mac_accumulator_pipelined
// Purpose  : Two-stage multiply-accumulate with clear, saturation and term count.
// Revision : 1.0
// ============================================================================
module mac_accumulator_pipelined
  import mac_pkg::*;
#(
  parameter int IN_WIDTH    = 8,
  parameter int ACC_WIDTH   = 24,
  parameter bit SIGNED_MODE = MAC_UNSIGNED,
  parameter bit SATURATE    = MAC_SAT,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clockPulse,
  input  logic                   Reset,
  input  logic                   inValid,
  input  logic                   clearAcc,
  input  logic [IN_WIDTH-1:0]    numberOne,
  input  logic [IN_WIDTH-1:0]    numberTwo,
  output logic [ACC_WIDTH-1:0]   Result,
  output logic                   resultValid,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] termCount
);

  generate
    if (ACC_WIDTH < 2 * IN_WIDTH || ACC_WIDTH > c_ACC_WIDTH_LIMIT) begin : g_bad_width
      $error("mac_accumulator_pipelined: ACC_WIDTH must lie in [2*IN_WIDTH, 64]");
    end
  endgenerate

  localparam logic [ACC_WIDTH-1:0] c_SAT_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH, SIGNED_MODE));
  localparam logic [ACC_WIDTH-1:0] c_SAT_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH, SIGNED_MODE));

  logic [ACC_WIDTH:0]     w_product;
  logic                   w_p_valid;
  logic                   w_p_clear;
  logic [ACC_WIDTH:0]     w_acc_ext;
  logic [ACC_WIDTH:0]     w_sum;
  logic                   w_ovf_event;
  logic                   w_ovf_neg;

  logic [ACC_WIDTH-1:0]   w_acc_d,   r_acc_q;
  logic [COUNT_WIDTH-1:0] w_cnt_d,   r_cnt_q;
  logic                   w_ovf_d,   r_ovf_q;
  logic                   w_rv_d,    r_rv_q;

  mac_product_stage #(
    .IN_WIDTH    (IN_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH),
    .SIGNED_MODE (SIGNED_MODE)
  ) u_product (
    .clk         (clockPulse),
    .rst         (Reset),
    .i_in_valid  (inValid),
    .i_clear_acc (clearAcc),
    .i_a         (numberOne),
    .i_b         (numberTwo),
    .o_product   (w_product),
    .o_p_valid   (w_p_valid),
    .o_p_clear   (w_p_clear)
  );

  always_comb begin
    w_acc_ext = {(SIGNED_MODE == MAC_SIGNED) ? r_acc_q[ACC_WIDTH-1] : 1'b0, r_acc_q};
    w_sum     = w_acc_ext + w_product;
    if (SIGNED_MODE == MAC_SIGNED) begin
      w_ovf_event = (r_acc_q[ACC_WIDTH-1] == w_product[ACC_WIDTH]) &&
                    (w_sum[ACC_WIDTH-1] != r_acc_q[ACC_WIDTH-1]);
      w_ovf_neg   = r_acc_q[ACC_WIDTH-1];
    end else begin
      w_ovf_event = w_sum[ACC_WIDTH];
      w_ovf_neg   = 1'b0;
    end

    w_acc_d = r_acc_q;
    w_cnt_d = r_cnt_q;
    w_ovf_d = r_ovf_q;
    w_rv_d  = w_p_valid || w_p_clear;

    if (w_p_clear) begin
      // A clear paired with a term starts the new sum with that term.
      w_acc_d = w_p_valid ? w_product[ACC_WIDTH-1:0] : '0;
      w_cnt_d = w_p_valid ? COUNT_WIDTH'(1) : '0;
      w_ovf_d = 1'b0;
    end else if (w_p_valid) begin
      w_acc_d = w_sum[ACC_WIDTH-1:0];
      if (w_ovf_event) begin
        w_ovf_d = 1'b1;
        if (SATURATE == MAC_SAT) begin
          w_acc_d = w_ovf_neg ? c_SAT_MIN : c_SAT_MAX;
        end
      end
      if (r_cnt_q != '1) begin
        w_cnt_d = r_cnt_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clockPulse or posedge Reset) begin
    if (Reset) begin
      r_acc_q <= '0;
      r_cnt_q <= '0;
      r_ovf_q <= 1'b0;
      r_rv_q  <= 1'b0;
    end else begin
      r_acc_q <= w_acc_d;
      r_cnt_q <= w_cnt_d;
      r_ovf_q <= w_ovf_d;
      r_rv_q  <= w_rv_d;
    end
  end

  assign Result      = r_acc_q;
  assign resultValid = r_rv_q;
  assign overflow    = r_ovf_q;
  assign termCount   = r_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator_pipelined.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mac_accumulator_pipelined
// Purpose  : Scoreboard bench driving four MAC configurations with one stream.
// Revision : 1.0
// ============================================================================
module tb_mac_accumulator_pipelined;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic clear_acc;
  logic [7:0] num_a;
  logic [7:0] num_b;

  logic [23:0] res0;
  logic [15:0] res1, res2, res3;
  logic [7:0]  cnt0, cnt1, cnt2, cnt3;
  logic [N-1:0] rv;
  logic [N-1:0] ovf;
  logic [N-1:0][23:0] res_all;
  logic [N-1:0][7:0]  cnt_all;

  assign res_all[0] = res0;
  assign res_all[1] = {8'd0, res1};
  assign res_all[2] = {8'd0, res2};
  assign res_all[3] = {8'd0, res3};
  assign cnt_all[0] = cnt0;
  assign cnt_all[1] = cnt1;
  assign cnt_all[2] = cnt2;
  assign cnt_all[3] = cnt3;

  always #5 clk = ~clk;

  mac_accumulator_pipelined #(.IN_WIDTH(8), .ACC_WIDTH(24), .SIGNED_MODE(1'b0), .SATURATE(1'b1), .COUNT_WIDTH(8)) u0 (
    .clockPulse(clk), .Reset(rst), .inValid(in_valid), .clearAcc(clear_acc), .numberOne(num_a), .numberTwo(num_b),
    .Result(res0), .resultValid(rv[0]), .overflow(ovf[0]), .termCount(cnt0));
  mac_accumulator_pipelined #(.IN_WIDTH(8), .ACC_WIDTH(16), .SIGNED_MODE(1'b0), .SATURATE(1'b1), .COUNT_WIDTH(8)) u1 (
    .clockPulse(clk), .Reset(rst), .inValid(in_valid), .clearAcc(clear_acc), .numberOne(num_a), .numberTwo(num_b),
    .Result(res1), .resultValid(rv[1]), .overflow(ovf[1]), .termCount(cnt1));
  mac_accumulator_pipelined #(.IN_WIDTH(8), .ACC_WIDTH(16), .SIGNED_MODE(1'b0), .SATURATE(1'b0), .COUNT_WIDTH(8)) u2 (
    .clockPulse(clk), .Reset(rst), .inValid(in_valid), .clearAcc(clear_acc), .numberOne(num_a), .numberTwo(num_b),
    .Result(res2), .resultValid(rv[2]), .overflow(ovf[2]), .termCount(cnt2));
  mac_accumulator_pipelined #(.IN_WIDTH(8), .ACC_WIDTH(16), .SIGNED_MODE(1'b1), .SATURATE(1'b1), .COUNT_WIDTH(8)) u3 (
    .clockPulse(clk), .Reset(rst), .inValid(in_valid), .clearAcc(clear_acc), .numberOne(num_a), .numberTwo(num_b),
    .Result(res3), .resultValid(rv[3]), .overflow(ovf[3]), .termCount(cnt3));

  function automatic int cfg_w(input int i);
    return (i == 0) ? 24 : 16;
  endfunction
  function automatic bit cfg_signed(input int i);
    return (i == 3);
  endfunction
  function automatic bit cfg_sat(input int i);
    return (i != 2);
  endfunction

  typedef struct {
    logic [N-1:0][23:0] res;
    logic [N-1:0][7:0]  cnt;
    logic [N-1:0]       ovf;
    int                 cyc;
  } exp_t;

  exp_t   sbq[$];
  exp_t   last;
  longint m_acc[N];
  int     m_cnt[N];
  bit     m_ovf[N];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_acc[i] = 0;
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
    end
    last.res = '0;
    last.cnt = '0;
    last.ovf = '0;
    last.cyc = 0;
  endtask

  // Reference: integer arithmetic against the representable range of each config.
  task automatic model_step(input bit v, input bit c, input logic [7:0] a, input logic [7:0] b);
    exp_t   e;
    longint pa, pb, s, hi, lo, m;
    for (int i = 0; i < N; i++) begin
      m  = 64'sd1 <<< cfg_w(i);
      hi = cfg_signed(i) ? (m / 2) - 1 : m - 1;
      lo = cfg_signed(i) ? -(m / 2) : 0;
      if (c) begin
        m_acc[i] = 0;
        m_cnt[i] = 0;
        m_ovf[i] = 1'b0;
      end
      if (v) begin
        pa = cfg_signed(i) ? longint'(signed'(a)) : longint'(a);
        pb = cfg_signed(i) ? longint'(signed'(b)) : longint'(b);
        s  = m_acc[i] + pa * pb;
        if (s > hi || s < lo) begin
          m_ovf[i] = 1'b1;
          if (cfg_sat(i)) begin
            s = (s > hi) ? hi : lo;
          end else begin
            s = s % m;
            if (s < 0) s = s + m;
            if (s > hi) s = s - m;
          end
        end
        m_acc[i] = s;
        if (m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
      end
      e.res[i] = 24'(m_acc[i] & (m - 1));
      e.cnt[i] = 8'(m_cnt[i]);
      e.ovf[i] = m_ovf[i];
    end
    e.cyc = cyc + 2;
    sbq.push_back(e);
  endtask

  task automatic issue(input bit v, input bit c, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in_valid  = v;
    clear_acc = c;
    num_a     = a;
    num_b     = b;
    if (v || c) model_step(v, c, a, b);
  endtask

  task automatic settle();
    repeat (3) issue(1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  // Monitor: a result is due exactly when the oldest expectation's cycle arrives.
  initial begin
    exp_t e;
    bit   due;
    forever begin
      @(negedge clk);
      if (!rst) begin
        due = (sbq.size() != 0) && (sbq[0].cyc == cyc);
        if (due) begin
          e    = sbq.pop_front();
          last = e;
        end
        for (int i = 0; i < N; i++) begin
          chk($sformatf("resultValid[%0d]", i), longint'(rv[i]), longint'(due));
          chk($sformatf("Result[%0d]", i), longint'(res_all[i]), longint'(last.res[i]));
          chk($sformatf("termCount[%0d]", i), longint'(cnt_all[i]), longint'(last.cnt[i]));
          chk($sformatf("overflow[%0d]", i), longint'(ovf[i]), longint'(last.ovf[i]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sp [4];
    logic [7:0] a, b;
    sp[0] = 8'hFF; sp[1] = 8'h80; sp[2] = 8'h7F; sp[3] = 8'h00;

    rst = 1'b1; in_valid = 1'b1; clear_acc = 1'b0; num_a = 8'd6; num_b = 8'd7;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset Result", longint'(res0), 0);
    chk("reset termCount", longint'(cnt0), 0);
    chk("reset valid", longint'(rv), 0);
    in_valid = 1'b0;
    #2 rst = 1'b0;

    issue(1, 0, 8'd2, 8'd3);
    issue(1, 0, 8'd5, 8'd9);
    issue(1, 0, 8'd5, 8'd0);
    settle();
    chk("seq Result", longint'(res0), 51);
    chk("seq termCount", longint'(cnt0), 3);

    issue(1, 0, 8'd7, 8'd8);
    issue(1, 1, 8'd4, 8'd4);
    settle();
    chk("clear+term Result", longint'(res0), 16);
    chk("clear+term termCount", longint'(cnt0), 1);
    chk("clear+term overflow", longint'(ovf[0]), 0);

    issue(1, 1, 8'd255, 8'd255);
    issue(1, 0, 8'd255, 8'd255);
    settle();
    chk("usat Result", longint'(res1), 65535);
    chk("usat overflow", longint'(ovf[1]), 1);
    chk("uwrap Result", longint'(res2), 64514);
    chk("uwrap overflow", longint'(ovf[2]), 1);
    issue(0, 1, 8'd0, 8'd0);
    settle();
    chk("clear-only Result", longint'(res1), 0);
    chk("clear-only overflow", longint'(ovf[1]), 0);

    issue(1, 1, 8'h80, 8'h80);
    issue(1, 0, 8'h80, 8'h80);
    settle();
    chk("ssat Result", longint'(res3), 32767);
    chk("ssat overflow", longint'(ovf[3]), 1);
    issue(1, 0, 8'd127, 8'h80);
    settle();
    chk("ssat resume Result", longint'(res3), 16511);

    // Asynchronous reset while a term sits in stage 1.
    issue(1, 0, 8'd200, 8'd100);
    @(posedge clk);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    clear_acc = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("async Result[%0d]", i), longint'(res_all[i]), 0);
      chk($sformatf("async termCount[%0d]", i), longint'(cnt_all[i]), 0);
    end
    chk("async overflow", longint'(ovf), 0);
    chk("async valid", longint'(rv), 0);
    sbq.delete();
    model_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    settle();

    // Long run without clear: default config saturates and count pins at all-ones.
    issue(1, 1, 8'd255, 8'd255);
    repeat (264) issue(1, 0, 8'd255, 8'd255);
    settle();
    chk("long Result", longint'(res0), 16777215);
    chk("long termCount", longint'(cnt0), 255);
    chk("long overflow", longint'(ovf[0]), 1);

    repeat (400) begin
      a = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : 8'($urandom);
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, a, b);
    end
    settle();
    chk("scoreboard drained", longint'(sbq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
